// File: rtl/wide_pack_fifo_pkg.sv
// rtl/wide_pack_fifo_pkg.sv - shared word/line geometry for the pack and unpack FIFOs
package wide_pack_fifo_pkg;
  localparam int DWI   = 32;
  localparam int RATIO = 56;
  localparam int DWO   = DWI * RATIO;
  localparam int CNTW  = $clog2(RATIO + 1);
  localparam int IDXW  = $clog2(RATIO);
endpackage

// File: rtl/wide_pack_fifo_line_packer.sv
// rtl/wide_pack_fifo_line_packer.sv - gathers narrow words into a staging line and strobes commit
module line_packer
  import wide_pack_fifo_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            accept,
  input  logic [DWI-1:0]  in_data,
  input  logic            in_last,
  output logic [DWO-1:0]  line,
  output logic [CNTW-1:0] line_cnt,
  output logic            commit
);

  logic [DWO-1:0]  stage;
  logic [IDXW-1:0] stage_cnt;

  assign commit   = accept && ((stage_cnt == IDXW'(RATIO - 1)) || in_last);
  assign line_cnt = CNTW'(stage_cnt) + CNTW'(1);

  // The committed line includes the word being accepted this cycle.
  always_comb begin
    line = stage;
    line[stage_cnt*DWI +: DWI] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      stage_cnt <= '0;
    end else if (commit) begin
      stage     <= '0;
      stage_cnt <= '0;
    end else if (accept) begin
      stage[stage_cnt*DWI +: DWI] <= in_data;
      stage_cnt                   <= stage_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wide_pack_fifo.sv
// rtl/wide_pack_fifo.sv - narrow-to-wide packing FIFO with first-word fall-through line buffer
module wide_pack_fifo
  import wide_pack_fifo_pkg::*;
#(
  parameter int AWL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DWI-1:0]  in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DWO-1:0]  out_data,
  output logic [CNTW-1:0] out_cnt,
  output logic [AWL:0]    level
);

  localparam int DEPTH = 1 << AWL;
  localparam logic [AWL:0] FULL = (AWL + 1)'(DEPTH);

  logic            run;
  logic [AWL-1:0]  wr_ptr;
  logic [AWL-1:0]  rd_ptr;
  logic            accept;
  logic            pop;
  logic            commit;
  logic [DWO-1:0]  line;
  logic [CNTW-1:0] line_cnt;
  logic [DWO-1:0]  mem     [DEPTH];
  logic [CNTW-1:0] cnt_mem [DEPTH];

  // run keeps in_ready low until the first edge after reset release.
  assign in_ready  = run && (level != FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign out_cnt   = cnt_mem[rd_ptr];

  line_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .in_data  (in_data),
    .in_last  (in_last),
    .line     (line),
    .line_cnt (line_cnt),
    .commit   (commit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      run <= 1'b1;
      if (commit) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({commit, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wr_ptr]     <= line;
      cnt_mem[wr_ptr] <= line_cnt;
    end
  end

endmodule

// File: tb/tb_wide_pack_fifo.sv
// tb/tb_wide_pack_fifo.sv - directed self-checking bench for wide_pack_fifo
module tb_wide_pack_fifo;
  import wide_pack_fifo_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DWI-1:0]  in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DWO-1:0]  out_data;
  logic [CNTW-1:0] out_cnt;
  logic [2:0]      level;

  int checks = 0;
  int errors = 0;
  int ovf = 0, under = 0;
  bit mon_en = 1'b0;
  int ready_drops = 0, lvl_bad = 0, nlines = 0, order_errs = 0;

  always #5 clk = ~clk;

  wide_pack_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .level     (level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return out_data[k*DWI +: DWI];
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.commit && level == 3'd4) ovf++;
      if (dut.pop && level == 3'd0) under++;
    end
    if (mon_en) begin
      if (!in_ready) ready_drops++;
      if (level > 3'd1) lvl_bad++;
      if (out_valid && out_ready) begin
        if (out_data[31:0] !== 32'h1000 + nlines*56 ||
            out_data[DWO-1 -: 32] !== 32'h1000 + nlines*56 + 55 ||
            out_cnt !== 6'd56) order_errs++;
        nlines++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_level", level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    check("ready_after_rst", in_ready, 1);

    // full line
    for (int k = 0; k < 56; k++) push(k, 1'b0);
    idle();
    check("full_valid", out_valid, 1);
    check("full_level", level, 1);
    check("full_cnt", out_cnt, 56);
    for (int k = 0; k < 56; k++) check("full_word", word(k), k);
    pop1();
    check("full_pop_level", level, 0);

    // short line, then a fresh line starts at word 0
    for (int k = 0; k < 10; k++) push(32'hA0 + k, k == 9);
    idle();
    check("short_cnt", out_cnt, 10);
    for (int k = 0; k < 10; k++) check("short_word", word(k), 32'hA0 + k);
    check("short_pad_zero", |out_data[DWO-1:320], 0);
    pop1();
    push(32'h55, 1'b1);
    idle();
    check("next_cnt", out_cnt, 1);
    check("next_word0", word(0), 32'h55);
    pop1();

    // fill to full, backpressure, single pop
    for (int j = 0; j < 224; j++) push(j, 1'b0);
    check("fill_ready", in_ready, 0);
    check("fill_level", level, 4);
    in_data = 32'hDEAD;
    cycles(3);
    idle();
    check("full_hold_level", level, 4);
    check("full_head", word(0), 0);
    pop1();
    check("after_pop_level", level, 3);
    check("after_pop_ready", in_ready, 1);
    check("after_pop_head", word(0), 56);
    out_ready = 1'b1;
    cycles(3);
    out_ready = 1'b0;
    check("drain_level", level, 0);

    // streaming
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int j = 0; j < 560; j++) push(32'h1000 + j, 1'b0);
    idle();
    cycles(3);
    mon_en = 1'b0;
    out_ready = 1'b0;
    check("stream_lines", nlines, 10);
    check("stream_order", order_errs, 0);
    check("stream_ready_drops", ready_drops, 0);
    check("stream_level_max", lvl_bad, 0);

    // commit and pop on the same edge
    push(32'h77, 1'b1);
    idle();
    check("cp_pre_level", level, 1);
    out_ready = 1'b1;
    push(32'h88, 1'b1);
    out_ready = 1'b0;
    idle();
    check("cp_level", level, 1);
    check("cp_head", word(0), 32'h88);
    check("cp_cnt", out_cnt, 1);
    pop1();

    // reset mid-line
    for (int k = 0; k < 20; k++) push(32'h200 + k, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_ready", in_ready, 0);
    cycles(2);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) push(32'h100 + k, k == 2);
    idle();
    check("rst_short_cnt", out_cnt, 3);
    check("rst_short_w0", word(0), 32'h100);
    check("rst_short_w3", word(3), 0);
    pop1();
    for (int k = 0; k < 56; k++) push(32'h100 + k, 1'b0);
    idle();
    check("rst_full_w0", word(0), 32'h100);
    check("rst_full_w19", word(19), 32'h113);
    check("rst_full_cnt", out_cnt, 56);
    pop1();

    // in_last on the final word
    for (int k = 0; k < 56; k++) push(32'h300 + k, k == 55);
    idle();
    check("last56_level", level, 1);
    check("last56_cnt", out_cnt, 56);
    cycles(3);
    check("last56_no_extra", level, 1);
    pop1();
    check("last56_empty", level, 0);
    check("last56_valid", out_valid, 0);

    check("no_overflow", ovf, 0);
    check("no_underflow", under, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
